// File: rtl/dlx_instr_encoder.sv
// dlx_instr_encoder: packs decoded fields into DLX words, expands LI32 into lhi+ori.
// Define DLX_DELAY_SLOT_NOP_EN to append a delay-slot nop after every branch/jump word.
module dlx_instr_encoder #(
   parameter int          CNT_W    = 16,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op_class,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [4:0]       rd,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:31]      instr,
   output logic             imm_ovf,
   output logic [CNT_W-1:0] word_cnt
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LI2  = 2'd1;
`ifdef DLX_DELAY_SLOT_NOP_EN
   localparam logic [1:0] NOPF = 2'd2;
`endif
   logic [1:0]  state;
   logic [1:0]  nxt;
   logic [4:0]  li_rd;
   logic [15:0] li_lo;
   logic        handoff;
   logic        accept;
   logic        uns;
   logic        ovf16;
   logic        ovf26;
   logic        is_jr;
   logic [31:0] enc;
   logic        enc_ovf;
   assign handoff  = out_valid && out_ready;
   assign in_ready = state == IDLE && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign uns      = opcode == 6'b001001 || opcode == 6'b001011;
   assign ovf16    = uns ? |imm[31:16] : !(imm[31:15] == '0 || &imm[31:15]);
   assign ovf26    = !(imm[31:25] == '0 || &imm[31:25]);
   assign is_jr    = opcode[5:1] == 5'b01001;
   // classes 2 (I-alu) and 3 (load) share the default rs1/rd/imm16 layout
   always_comb begin
      enc     = {opcode, rs1, rd, imm[15:0]};
      enc_ovf = ovf16;
      case (op_class)
         3'd0: {enc, enc_ovf} = {6'b000000, rs1, rs2, rd, 5'b0, funct, 1'b0};
         3'd1: {enc, enc_ovf} = {6'b000001, rs1, rs2, rd, 5'b0, funct, 1'b0};
         3'd4: enc = {opcode, rs1, rs2, imm[15:0]};
         3'd5: enc = {opcode, rs1, 5'b0, imm[15:0]};
         3'd6: {enc, enc_ovf} = is_jr ? {opcode, rs1, 21'b0, 1'b0} : {opcode, imm[25:0], ovf26};
         3'd7: {enc, enc_ovf} = {6'b001111, 5'b0, rd, imm[31:16], 1'b0};
         default: ;
      endcase
   end
`ifdef DLX_DELAY_SLOT_NOP_EN
   assign nxt = op_class == 3'd7 ? LI2 : (op_class == 3'd5 || op_class == 3'd6) ? NOPF : IDLE;
`else
   assign nxt = op_class == 3'd7 ? LI2 : IDLE;
`endif
   // LI2/NOPF mean "a follow-up word is owed once the current word is taken"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         instr     <= NOP_WORD;
         imm_ovf   <= 1'b0;
         word_cnt  <= '0;
         li_rd     <= '0;
         li_lo     <= '0;
      end else begin
         if (handoff) word_cnt <= word_cnt + CNT_W'(1);
         if (accept) begin
            out_valid <= 1'b1;
            instr     <= enc;
            imm_ovf   <= enc_ovf;
            state     <= nxt;
            li_rd     <= rd;
            li_lo     <= imm[15:0];
         end else if (handoff && state == LI2) begin
            instr   <= {6'b001101, li_rd, li_rd, li_lo};
            imm_ovf <= 1'b0;
            state   <= IDLE;
`ifdef DLX_DELAY_SLOT_NOP_EN
         end else if (handoff && state == NOPF) begin
            instr   <= NOP_WORD;
            imm_ovf <= 1'b0;
            state   <= IDLE;
`endif
         end else if (handoff) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dlx_instr_encoder.sv
// tb_dlx_instr_encoder: directed vector table, hand-written corner sequences, and
// randomized traffic against a word-queue reference model.
module tb_dlx_instr_encoder;
   localparam int CW = 4;
   typedef struct packed {
      logic [31:0] w;
      logic        o;
   } word_t;
   typedef struct {
      logic [2:0]  c;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [4:0]  d;
      logic [31:0] im;
      logic [31:0] ew;
      logic        eo;
   } vec_t;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic          imm_ovf;
   logic [2:0]    op_class = '0;
   logic [5:0]    opcode = '0;
   logic [5:0]    funct = '0;
   logic [4:0]    rs1 = '0;
   logic [4:0]    rs2 = '0;
   logic [4:0]    rd = '0;
   logic [31:0]   imm = '0;
   logic [0:31]   instr;
   logic [CW-1:0] word_cnt;
   int            n_tests = 0;
   int            n_fail = 0;
   int            mcnt = 0;
   word_t         q[$];
   vec_t          tbl[13];
   vec_t          li;
   vec_t          v;
   always #5 clk = ~clk;
   dlx_instr_encoder #(.CNT_W(CW), .NOP_WORD(32'h00000013)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_class(op_class), .opcode(opcode), .funct(funct), .rs1(rs1), .rs2(rs2),
      .rd(rd), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
      .instr(instr), .imm_ovf(imm_ovf), .word_cnt(word_cnt)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic drive(input vec_t x);
      op_class = x.c;
      opcode   = x.opc;
      funct    = x.fn;
      rs1      = x.a;
      rs2      = x.b;
      rd       = x.d;
      imm      = x.im;
   endtask
   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      mcnt = 0;
   endtask
   // Reference: build each word by shifting fields into place, range-check the immediate numerically.
   function automatic void push_model(input vec_t x);
      int          si  = $signed(x.im);
      logic [31:0] op  = 32'(x.opc) << 26;
      logic [31:0] lo  = x.im & 32'hFFFF;
      logic        uns = x.opc == 6'd9 || x.opc == 6'd11;
      logic        o16 = uns ? (x.im > 32'd65535) : (si < -32768 || si > 32767);
      case (x.c)
         3'd0, 3'd1: q.push_back('{w: (32'(x.c) << 26) | (32'(x.a) << 21) | (32'(x.b) << 16) | (32'(x.d) << 11) | 32'(x.fn), o: 1'b0});
         3'd2, 3'd3: q.push_back('{w: op | (32'(x.a) << 21) | (32'(x.d) << 16) | lo, o: o16});
         3'd4: q.push_back('{w: op | (32'(x.a) << 21) | (32'(x.b) << 16) | lo, o: o16});
         3'd5: q.push_back('{w: op | (32'(x.a) << 21) | lo, o: o16});
         3'd6: begin
            if ((x.opc >> 1) == 6'd9) q.push_back('{w: op | (32'(x.a) << 21), o: 1'b0});
            else q.push_back('{w: op | (x.im & 32'h03FFFFFF), o: (si < -(1 << 25) || si >= (1 << 25))});
         end
         default: begin
            q.push_back('{w: (32'd15 << 26) | (32'(x.d) << 16) | (x.im >> 16), o: 1'b0});
            q.push_back('{w: (32'd13 << 26) | (32'(x.d) << 21) | (32'(x.d) << 16) | lo, o: 1'b0});
         end
      endcase
`ifdef DLX_DELAY_SLOT_NOP_EN
      if (x.c == 3'd5 || x.c == 3'd6) q.push_back('{w: 32'h00000013, o: 1'b0});
`endif
   endfunction
   initial begin
      logic [5:0]  opl[6];
      logic [31:0] bnd[10];
      logic [15:0] t16;
      logic        rdy;
      opl = '{6'd9, 6'd11, 6'd2, 6'd3, 6'd18, 6'd19};
      bnd = '{32'h00007FFF, 32'h00008000, 32'hFFFF8000, 32'hFFFF7FFF, 32'h0000FFFF,
              32'h00010000, 32'h01FFFFFF, 32'h02000000, 32'hFE000000, 32'hFDFFFFFF};
      tbl[0]  = '{3'd0, 6'h00, 6'h20, 5'd1,  5'd2, 5'd3,  32'h00000000, 32'h00221820, 1'b0};
      tbl[1]  = '{3'd2, 6'h08, 6'h00, 5'd4,  5'd0, 5'd5,  32'hFFFFFFFF, 32'h2085FFFF, 1'b0};
      tbl[2]  = '{3'd2, 6'h08, 6'h00, 5'd4,  5'd0, 5'd5,  32'h00010000, 32'h20850000, 1'b1};
      tbl[3]  = '{3'd1, 6'h3F, 6'h00, 5'd1,  5'd2, 5'd3,  32'hDEADBEEF, 32'h04221800, 1'b0};
      tbl[4]  = '{3'd2, 6'h09, 6'h00, 5'd1,  5'd0, 5'd2,  32'h0000FFFF, 32'h2422FFFF, 1'b0};
      tbl[5]  = '{3'd2, 6'h09, 6'h00, 5'd1,  5'd0, 5'd2,  32'hFFFFFFFF, 32'h2422FFFF, 1'b1};
      tbl[6]  = '{3'd4, 6'h2B, 6'h00, 5'd3,  5'd4, 5'd31, 32'hFFFF8000, 32'hAC648000, 1'b0};
      tbl[7]  = '{3'd3, 6'h23, 6'h00, 5'd3,  5'd0, 5'd9,  32'h00008000, 32'h8C698000, 1'b1};
      tbl[8]  = '{3'd6, 6'h02, 6'h00, 5'd0,  5'd0, 5'd0,  32'h03FFFFFF, 32'h0BFFFFFF, 1'b1};
      tbl[9]  = '{3'd6, 6'h03, 6'h00, 5'd0,  5'd0, 5'd0,  32'hFFFFFFFC, 32'h0FFFFFFC, 1'b0};
      tbl[10] = '{3'd6, 6'h12, 6'h00, 5'd31, 5'd0, 5'd0,  32'hFFFF0000, 32'h4BE00000, 1'b0};
      tbl[11] = '{3'd5, 6'h04, 6'h00, 5'd2,  5'd0, 5'd0,  32'h00000008, 32'h10400008, 1'b0};
      tbl[12] = '{3'd5, 6'h05, 6'h00, 5'd2,  5'd0, 5'd0,  32'h00008000, 32'h14408000, 1'b1};
      li      = '{3'd7, 6'h00, 6'h00, 5'd0,  5'd0, 5'd7,  32'h12345678, 32'h0, 1'b0};
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset instr", instr, 32'h00000013);
      chk("reset imm_ovf", 32'(imm_ovf), 32'd0);
      chk("reset word_cnt", 32'(word_cnt), 32'd0);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         in_valid = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
         chk($sformatf("vec%0d instr", i), instr, tbl[i].ew);
         chk($sformatf("vec%0d imm_ovf", i), 32'(imm_ovf), 32'(tbl[i].eo));
         repeat (3) @(posedge clk);
         if (i == 0) chk("vec0 word_cnt", 32'(word_cnt), 32'd1);
      end
      // LI32 expands into lhi then ori, input stalled in between
      reset_dut();
      @(negedge clk);
      drive(li);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("li32 lhi", instr, 32'h3C071234);
      chk("li32 in_ready", 32'(in_ready), 32'd0);
      chk("li32 lhi ovf", 32'(imm_ovf), 32'd0);
      @(posedge clk);
      #1 chk("li32 ori", instr, 32'h34E75678);
      chk("li32 ori valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1 chk("li32 drained", 32'(out_valid), 32'd0);
      chk("li32 word_cnt", 32'(word_cnt), 32'd2);
      // backpressure: word held, nothing accepted, then back-to-back on release
      reset_dut();
      out_ready = 1'b0;
      @(negedge clk);
      drive(tbl[1]);
      in_valid = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(tbl[0]);
         #1 chk($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
         chk($sformatf("bp%0d instr", k), instr, tbl[1].ew);
         chk($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("bp release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 chk("bp B", instr, tbl[0].ew);
      @(negedge clk);
      drive(tbl[2]);
      @(posedge clk);
      #1 chk("bp C", instr, tbl[2].ew);
      chk("bp C valid", 32'(out_valid), 32'd1);
      chk("bp C ovf", 32'(imm_ovf), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1 chk("bp drained", 32'(out_valid), 32'd0);
      chk("bp word_cnt", 32'(word_cnt), 32'd3);
      // async reset while the ori is still owed
      reset_dut();
      @(negedge clk);
      drive(tbl[0]);
      in_valid = 1'b1;
      @(negedge clk);
      drive(li);
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b0;
      chk("rst li2 lhi", instr, 32'h3C071234);
      #2 rst_n = 1'b0;
      #1 chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst instr", instr, 32'h00000013);
      chk("rst word_cnt", 32'(word_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      drive(tbl[3]);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("rst next instr", instr, tbl[3].ew);
      @(posedge clk);
      #1 chk("rst no stale ori", 32'(out_valid), 32'd0);
      chk("rst next word_cnt", 32'(word_cnt), 32'd1);
`ifdef DLX_DELAY_SLOT_NOP_EN
      reset_dut();
      @(negedge clk);
      drive(tbl[11]);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("ds branch", instr, 32'h10400008);
      chk("ds in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 chk("ds nop", instr, 32'h00000013);
      chk("ds nop valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1 chk("ds drained", 32'(out_valid), 32'd0);
      chk("ds word_cnt", 32'(word_cnt), 32'd2);
`endif
      reset_dut();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         v.c   = 3'($urandom_range(0, 7));
         v.opc = ($urandom_range(0, 2) == 0) ? opl[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
         v.fn  = 6'($urandom);
         v.a   = 5'($urandom);
         v.b   = 5'($urandom);
         v.d   = 5'($urandom);
         t16   = 16'($urandom);
         case ($urandom_range(0, 3))
            0: v.im = $urandom;
            1: v.im = {{16{t16[15]}}, t16};
            2: v.im = bnd[$urandom_range(0, 9)];
            default: v.im = $urandom_range(0, 70000);
         endcase
         drive(v);
         in_valid  = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 7;
         #1 rdy = q.size() == 0 || (q.size() == 1 && out_ready);
         chk("rnd out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("rnd in_ready", 32'(in_ready), 32'(rdy));
         chk("rnd word_cnt", 32'(word_cnt), 32'(mcnt));
         if (q.size() > 0) begin
            chk("rnd instr", instr, q[0].w);
            chk("rnd imm_ovf", 32'(imm_ovf), 32'(q[0].o));
         end
         if (q.size() > 0 && out_ready) begin
            void'(q.pop_front());
            mcnt = (mcnt + 1) % (1 << CW);
         end
         if (in_valid && rdy) push_model(v);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      mcnt = (mcnt + q.size()) % (1 << CW);
      q.delete();
      repeat (4) @(posedge clk);
      #1 chk("rnd drain out_valid", 32'(out_valid), 32'd0);
      chk("rnd drain word_cnt", 32'(word_cnt), 32'(mcnt));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
